// File: rtl/capture_control_if.sv
// ASHI register-access interface between the axi4_lite_slave core and capture_control.
interface capture_control_if;
  logic [31:0] ashi_windx;
  logic [31:0] ashi_wdata;
  logic        ashi_write;
  logic [1:0]  ashi_wresp;
  logic        ashi_widle;
  logic [31:0] ashi_rindx;
  logic        ashi_read;
  logic [31:0] ashi_rdata;
  logic [1:0]  ashi_rresp;
  logic        ashi_ridle;

  modport master (
    output ashi_windx, ashi_wdata, ashi_write, ashi_rindx, ashi_read,
    input  ashi_wresp, ashi_widle, ashi_rdata, ashi_rresp, ashi_ridle
  );

  modport slave (
    input  ashi_windx, ashi_wdata, ashi_write, ashi_rindx, ashi_read,
    output ashi_wresp, ashi_widle, ashi_rdata, ashi_rresp, ashi_ridle
  );
endinterface

// File: rtl/capture_control.sv
// Capture sequencer: downstream reset, RAM calibration wait, bank erase, packet gate.
// Optional interrupt output and IRQ_ENABLE register under CAPTURE_CTL_IRQ_EN.

module cdc_single (
  input  logic clk,
  input  logic resetn,
  input  logic d_async,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// state      | meaning
// IDLE (0)   | waiting for start, gate closed
// RESET (1)  | sys_reset_out asserted
// SETTLE (2) | reset released, letting the datapath settle
// WAIT_CAL(3)| waiting for all banks calibrated
// WAIT_BUSY(4)| erase issued, waiting for any bank to go busy
// WAIT_IDLE(5)| erasing, waiting for all banks idle
// RUN (6)    | gate open
module capture_control #(
  parameter int unsigned NUM_BANKS          = 4,
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned RESET_CYCLES       = 20,
  parameter int unsigned SETTLE_CYCLES      = 20,
  parameter int unsigned ERASE_START_CYCLES = 20,
  parameter int unsigned CALIB_TIMEOUT      = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 resetn,
  capture_control_if.slave     ashi,
  input  logic [NUM_BANKS-1:0] calib_complete_async,
  input  logic [NUM_BANKS-1:0] erase_idle_async,
  input  logic [NUM_PORTS-1:0] qsfp_status_async,
  output logic                 sys_reset_out,
  output logic                 eth_resetn_out,
  output logic                 erase_ram,
  output logic                 packet_gate,
`ifdef CAPTURE_CTL_IRQ_EN
  output logic                 irq,
`endif
  output logic [NUM_PORTS-1:0] led_l
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_SETTLE    = 3'd2,
    S_WAIT_CAL  = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_RUN       = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The timer holds the cycles remaining after the current one, so loading N keeps a state for N cycles.
  function automatic logic [31:0] load_val(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

  logic [NUM_BANKS-1:0] calib_sync, erase_idle_sync;
  logic [NUM_PORTS-1:0] qsfp_sync;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank_sync
    cdc_single u_calib (.clk(clk), .resetn(resetn), .d_async(calib_complete_async[i]), .q(calib_sync[i]));
    cdc_single u_erase (.clk(clk), .resetn(resetn), .d_async(erase_idle_async[i]), .q(erase_idle_sync[i]));
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port_sync
    cdc_single u_qsfp (.clk(clk), .resetn(resetn), .d_async(qsfp_status_async[i]), .q(qsfp_sync[i]));
  end

  logic calib_all, erase_idle_all;
  assign calib_all      = &calib_sync;
  assign erase_idle_all = &erase_idle_sync;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        sys_reset_q, sys_reset_d;
  logic        eth_resetn_q, eth_resetn_d;
  logic        erase_ram_q, erase_ram_d;
  logic        gate_q, gate_d;
  logic [1:0]  wresp_q, wresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] erase_timeout_q, erase_timeout_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;

  logic        wr_capture, start_req, stop_req;
  logic [1:0]  err_set, w1c;
  logic        gate_open, erase_go;
  logic [7:0]  calib8, qsfp8;

  assign wr_capture = ashi.ashi_write && (ashi.ashi_windx == 32'd0);
  assign start_req  = wr_capture && (ashi.ashi_wdata != 32'd0);
  assign stop_req   = wr_capture && (ashi.ashi_wdata == 32'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      timer_q         <= 32'd0;
      sys_reset_q     <= 1'b0;
      eth_resetn_q    <= 1'b1;
      erase_ram_q     <= 1'b0;
      gate_q          <= 1'b0;
      wresp_q         <= RESP_OKAY;
      rresp_q         <= RESP_OKAY;
      rdata_q         <= 32'd0;
      erase_timeout_q <= 32'd1_000_000;
      count_q         <= 32'd0;
      err_q           <= 2'b00;
      irq_en_q        <= 2'b00;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      sys_reset_q     <= sys_reset_d;
      eth_resetn_q    <= eth_resetn_d;
      erase_ram_q     <= erase_ram_d;
      gate_q          <= gate_d;
      wresp_q         <= wresp_d;
      rresp_q         <= rresp_d;
      rdata_q         <= rdata_d;
      erase_timeout_q <= erase_timeout_d;
      count_q         <= count_d;
      err_q           <= err_d;
      irq_en_q        <= irq_en_d;
      irq_q           <= irq_d;
    end
  end

  // Success in a wait state is checked before its timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
    err_set   = 2'b00;
    gate_open = 1'b0;
    erase_go  = 1'b0;
    if (stop_req) begin
      state_d = S_IDLE;
      timer_d = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (start_req) begin
          state_d = S_RESET;
          timer_d = load_val(RESET_CYCLES);
        end
        S_RESET: if (timer_q == 32'd0) begin
          state_d = S_SETTLE;
          timer_d = load_val(SETTLE_CYCLES);
        end
        S_SETTLE: if (timer_q == 32'd0) begin
          state_d = S_WAIT_CAL;
          timer_d = load_val(CALIB_TIMEOUT);
        end
        S_WAIT_CAL: if (calib_all) begin
          state_d  = S_WAIT_BUSY;
          timer_d  = load_val(ERASE_START_CYCLES);
          erase_go = 1'b1;
        end else if (timer_q == 32'd0) begin
          state_d    = S_IDLE;
          err_set[0] = 1'b1;
        end
        S_WAIT_BUSY: if (!erase_idle_all) begin
          state_d = S_WAIT_IDLE;
          timer_d = load_val(erase_timeout_q);
        end else if (timer_q == 32'd0) begin
          state_d    = S_IDLE;
          err_set[1] = 1'b1;
        end
        S_WAIT_IDLE: if (erase_idle_all) begin
          state_d   = S_RUN;
          gate_open = 1'b1;
        end else if (timer_q == 32'd0) begin
          state_d    = S_IDLE;
          err_set[1] = 1'b1;
        end
        S_RUN: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sys_reset_d = sys_reset_q;
    gate_d      = gate_q;
    erase_ram_d = erase_go;
    count_d     = count_q;
    if (stop_req) begin
      sys_reset_d = 1'b0;
      gate_d      = 1'b0;
      erase_ram_d = 1'b0;
    end else begin
      if (state_q == S_IDLE && start_req) begin
        sys_reset_d = 1'b1;
        gate_d      = 1'b0;
      end
      if (state_q == S_RESET && timer_q == 32'd0)
        sys_reset_d = 1'b0;
      if (gate_open) begin
        gate_d  = 1'b1;
        count_d = count_q + 32'd1;
      end
    end
    // A clear that lands on the same cycle as a new error loses.
    err_d = (err_q & ~w1c) | err_set;
    irq_d = (irq_en_q[0] & gate_open) | (irq_en_q[1] & (|err_set));
  end

  always_comb begin
    calib8 = 8'd0;
    qsfp8  = 8'd0;
    calib8[NUM_BANKS-1:0] = calib_sync;
    qsfp8[NUM_PORTS-1:0]  = qsfp_sync;
  end

  always_comb begin
    wresp_d         = wresp_q;
    eth_resetn_d    = eth_resetn_q;
    erase_timeout_d = erase_timeout_q;
    irq_en_d        = irq_en_q;
    w1c             = 2'b00;
    if (ashi.ashi_write) begin
      wresp_d = RESP_OKAY;
      case (ashi.ashi_windx)
        32'd0: if (start_req && state_q != S_IDLE) wresp_d = RESP_SLVERR;
        32'd1, 32'd4: ;
        32'd2: eth_resetn_d = ashi.ashi_wdata[0];
        32'd3: erase_timeout_d = ashi.ashi_wdata;
        32'd5: w1c = ashi.ashi_wdata[1:0];
`ifdef CAPTURE_CTL_IRQ_EN
        32'd6: irq_en_d = ashi.ashi_wdata[1:0];
`endif
        default: wresp_d = RESP_DECERR;
      endcase
    end

    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ashi.ashi_read) begin
      rresp_d = RESP_OKAY;
      case (ashi.ashi_rindx)
        32'd0: rdata_d = {29'd0, state_q};
        32'd1: rdata_d = {12'd0, err_q, gate_q, ~erase_idle_all, calib8, qsfp8};
        32'd2: rdata_d = {31'd0, eth_resetn_q};
        32'd3: rdata_d = erase_timeout_q;
        32'd4: rdata_d = count_q;
        32'd5: rdata_d = {30'd0, err_q};
`ifdef CAPTURE_CTL_IRQ_EN
        32'd6: rdata_d = {30'd0, irq_en_q};
`endif
        default: rdata_d = 32'd0;
      endcase
    end
  end

  assign ashi.ashi_widle = ~ashi.ashi_write;
  assign ashi.ashi_ridle = ~ashi.ashi_read;
  assign ashi.ashi_wresp = wresp_q;
  assign ashi.ashi_rresp = rresp_q;
  assign ashi.ashi_rdata = rdata_q;

  assign sys_reset_out  = sys_reset_q;
  assign eth_resetn_out = eth_resetn_q;
  assign erase_ram      = erase_ram_q;
  assign packet_gate    = gate_q;
  assign led_l          = ~qsfp_sync;
`ifdef CAPTURE_CTL_IRQ_EN
  assign irq            = irq_q;
`else
  logic irq_unused;
  assign irq_unused = irq_q ^ (|irq_en_q);
`endif

endmodule

// File: tb/tb_capture_control.sv
// Self-checking bench for capture_control: register table, directed sequences, randomized captures.
`timescale 1ns/1ps
module tb_capture_control;
  localparam int NB     = 4;
  localparam int NP     = 4;
  localparam int CAL_TO = 1000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NB-1:0] calib_in = '0;
  logic [NB-1:0] erase_idle_in;
  logic [NP-1:0] qsfp_in = '0;
  logic          sys_reset_out, eth_resetn_out, erase_ram, packet_gate;
  logic [NP-1:0] led_l;
`ifdef CAPTURE_CTL_IRQ_EN
  logic          irq;
`endif

  capture_control_if bus ();

  capture_control #(
    .NUM_BANKS(NB), .NUM_PORTS(NP), .CALIB_TIMEOUT(CAL_TO)
  ) dut (
    .clk(clk), .resetn(resetn), .ashi(bus),
    .calib_complete_async(calib_in), .erase_idle_async(erase_idle_in),
    .qsfp_status_async(qsfp_in),
    .sys_reset_out(sys_reset_out), .eth_resetn_out(eth_resetn_out),
    .erase_ram(erase_ram), .packet_gate(packet_gate),
`ifdef CAPTURE_CTL_IRQ_EN
    .irq(irq),
`endif
    .led_l(led_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic widle_seen, ridle_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] idx, input logic [31:0] data, output logic [1:0] resp);
    bus.ashi_windx = idx;
    bus.ashi_wdata = data;
    bus.ashi_write = 1'b1;
    #1;
    widle_seen = bus.ashi_widle;
    tick();
    bus.ashi_write = 1'b0;
    resp = bus.ashi_wresp;
  endtask

  task automatic rd(input logic [31:0] idx, output logic [31:0] data, output logic [1:0] resp);
    bus.ashi_rindx = idx;
    bus.ashi_read  = 1'b1;
    #1;
    ridle_seen = bus.ashi_ridle;
    tick();
    bus.ashi_read = 1'b0;
    data = bus.ashi_rdata;
    resp = bus.ashi_rresp;
  endtask

  task automatic rd_chk(input logic [31:0] idx, input logic [31:0] exp, input string name);
    logic [31:0] d;
    logic [1:0]  r;
    rd(idx, d, r);
    check(name, d, exp);
  endtask

  // Eraser model: goes busy er_d1 cycles after an erase strobe, stays busy er_d2 cycles.
  int er_d1 = -1;
  int er_d2 = 0;
  initial begin
    erase_idle_in = '1;
    forever begin
      @(negedge clk);
      if (erase_ram === 1'b1 && er_d1 >= 0) begin
        repeat (er_d1) @(negedge clk);
        erase_idle_in = '0;
        repeat (er_d2) @(negedge clk);
        erase_idle_in = '1;
      end
    end
  end

  int srst_run = 0, srst_last = 0, er_run = 0, er_max = 0, er_pulses = 0;
  always @(negedge clk) begin
    if (sys_reset_out === 1'b1) srst_run++;
    else if (srst_run != 0) begin
      srst_last = srst_run;
      srst_run  = 0;
    end
    if (erase_ram === 1'b1) begin
      er_run++;
      if (er_run == 1) er_pulses++;
      if (er_run > er_max) er_max = er_run;
    end else er_run = 0;
  end

  task automatic wait_gate(input int budget, input string name);
    int n = 0;
    while (packet_gate !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, packet_gate, 1'b1);
  endtask

  task automatic wait_pulse(input int target, input int budget, input string name);
    int n = 0;
    while (er_pulses < target && n < budget) begin
      tick();
      n++;
    end
    check(name, er_pulses, target);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] idx;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        eth;
    string       name;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit w, input logic [31:0] idx, input logic [31:0] data,
                              input logic [1:0] resp, input logic [31:0] rdata,
                              input logic eth, input string nm);
    vec_t v;
    v.is_wr = w; v.idx = idx; v.data = data; v.resp = resp;
    v.rdata = rdata; v.eth = eth; v.name = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          model_count;
    bit          cal_never, bsy_never, long_b;
    int          cal_d;
    logic [31:0] exp_state;
    logic [1:0]  exp_err;

    bus.ashi_windx = '0; bus.ashi_wdata = '0; bus.ashi_write = 1'b0;
    bus.ashi_rindx = '0; bus.ashi_read = 1'b0;

    // Reset state
    resetn = 1'b0;
    tick(3);
    check("rst sys_reset_out", sys_reset_out, 1'b0);
    check("rst eth_resetn_out", eth_resetn_out, 1'b1);
    check("rst packet_gate", packet_gate, 1'b0);
    check("rst erase_ram", erase_ram, 1'b0);
    check("rst led_l", led_l, 4'hF);
    check("rst wresp", bus.ashi_wresp, 2'b00);
    check("rst rdata", bus.ashi_rdata, 32'd0);
    check("rst widle", bus.ashi_widle, 1'b1);
    check("rst ridle", bus.ashi_ridle, 1'b1);
    resetn = 1'b1;
    tick();
    rd_chk(32'd4, 32'd0, "rst count");

    qsfp_in  = 4'h5;
    calib_in = 4'hF;
    tick(3);
    check("led follows qsfp", led_l, 4'hA);

    add(0, 0, 0, 2'b00, 32'd0, 1, "rd state idle");
    add(0, 1, 0, 2'b00, 32'h0000_0F05, 1, "rd status idle");
    add(0, 3, 0, 2'b00, 32'd1_000_000, 1, "rd erase_timeout rst");
    add(1, 3, 100, 2'b00, 0, 1, "wr erase_timeout");
    add(0, 3, 0, 2'b00, 32'd100, 1, "rd erase_timeout");
    add(1, 2, 0, 2'b00, 0, 0, "wr eth 0");
    add(0, 2, 0, 2'b00, 32'd0, 0, "rd eth 0");
    add(1, 2, 1, 2'b00, 0, 1, "wr eth 1");
    add(0, 2, 0, 2'b00, 32'd1, 1, "rd eth 1");
    add(1, 9, 5, 2'b11, 0, 1, "wr unmapped 9");
    add(0, 9, 0, 2'b00, 32'd0, 1, "rd unmapped 9");
    add(1, 32'h8000_0000, 1, 2'b11, 0, 1, "wr unmapped high");
`ifdef CAPTURE_CTL_IRQ_EN
    add(1, 6, 0, 2'b00, 0, 1, "wr irq_enable");
`else
    add(1, 6, 3, 2'b11, 0, 1, "wr unmapped 6");
`endif
    add(0, 6, 0, 2'b00, 32'd0, 1, "rd idx 6");
    add(0, 5, 0, 2'b00, 32'd0, 1, "rd error");
    add(1, 4, 7, 2'b00, 0, 1, "wr count ro");
    add(0, 4, 0, 2'b00, 32'd0, 1, "rd count");

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].idx, tbl[i].data, r);
        check({tbl[i].name, " wresp"}, r, tbl[i].resp);
        check({tbl[i].name, " widle"}, widle_seen, 1'b0);
      end else begin
        rd(tbl[i].idx, d, r);
        check({tbl[i].name, " rdata"}, d, tbl[i].rdata);
        check({tbl[i].name, " rresp"}, r, tbl[i].resp);
        check({tbl[i].name, " ridle"}, ridle_seen, 1'b0);
      end
      check({tbl[i].name, " eth_resetn_out"}, eth_resetn_out, tbl[i].eth);
    end

    // Full capture
    er_d1 = 5; er_d2 = 50;
    wr(0, 1, r);
    check("start wresp", r, 2'b00);
    check("start sys_reset_out", sys_reset_out, 1'b1);
    wait_gate(600, "capture gate open");
    check("sys_reset width", srst_last, 32'd20);
    check("erase pulses", er_pulses, 1);
    check("erase pulse width", er_max, 1);
    rd_chk(4, 1, "count after capture");
    rd_chk(0, 6, "state run");
    wr(0, 0, r);
    check("stop after capture gate", packet_gate, 1'b0);

    // Calibration timeout
    calib_in = 4'h0;
    tick(3);
    wr(0, 1, r);
    tick(500);
    rd_chk(0, 3, "state wait_cal");
    tick(600);
    rd_chk(0, 0, "state after calib timeout");
    rd_chk(5, 1, "error calib timeout");
    check("gate after calib timeout", packet_gate, 1'b0);
    wr(5, 1, r);
    rd_chk(5, 0, "error cleared");

    // Erase never busy
    calib_in = 4'hF;
    er_d1 = -1;
    tick(3);
    wr(0, 1, r);
    wait_pulse(2, 200, "erase strobe no-busy run");
    tick(5);
    rd_chk(0, 4, "state wait_busy");
    tick(40);
    rd_chk(0, 0, "state after busy timeout");
    rd_chk(5, 2, "error no busy");
    wr(5, 2, r);

    // Busy beyond erase timeout
    er_d1 = 2; er_d2 = 300;
    wr(0, 1, r);
    wait_pulse(3, 200, "erase strobe long-busy run");
    tick(50);
    rd_chk(0, 5, "state wait_idle");
    tick(120);
    rd_chk(0, 0, "state after idle timeout");
    rd_chk(5, 2, "error idle timeout");
    tick(200);
    wr(5, 3, r);

    // Start while running, stop, unmapped
    er_d1 = 3; er_d2 = 20;
    wr(0, 1, r);
    wait_gate(300, "second capture gate open");
    wr(0, 1, r);
    check("start in run wresp", r, 2'b10);
    check("start in run gate", packet_gate, 1'b1);
    rd_chk(0, 6, "state still run");
    wr(0, 0, r);
    check("stop wresp", r, 2'b00);
    check("stop gate", packet_gate, 1'b0);
    rd_chk(0, 0, "state after stop");
    rd_chk(4, 2, "count two captures");
    wr(9, 1, r);
    check("decerr idx9", r, 2'b11);
    rd(9, d, r);
    check("rd idx9 data", d, 0);
    check("rd idx9 resp", r, 2'b00);

    // resetn during WAIT_IDLE
    wr(2, 0, r);
    check("eth_resetn_out low", eth_resetn_out, 1'b0);
    er_d1 = 3; er_d2 = 80;
    wr(0, 1, r);
    wait_pulse(5, 200, "erase strobe before reset");
    tick(20);
    rd_chk(0, 5, "state wait_idle before reset");
    resetn = 1'b0;
    tick();
    check("mid rst sys_reset_out", sys_reset_out, 1'b0);
    check("mid rst eth_resetn_out", eth_resetn_out, 1'b1);
    check("mid rst erase_ram", erase_ram, 1'b0);
    check("mid rst gate", packet_gate, 1'b0);
    check("mid rst rdata", bus.ashi_rdata, 0);
    check("mid rst wresp", bus.ashi_wresp, 2'b00);
    tick();
    resetn = 1'b1;
    tick();
    rd_chk(0, 0, "state after mid reset");
    rd_chk(4, 0, "count after mid reset");
    rd_chk(3, 32'd1_000_000, "erase_timeout after mid reset");
    tick(100);

    // Randomized captures against an outcome model
    wr(3, 100, r);
    model_count = 0;
    for (int it = 0; it < 12; it++) begin
      calib_in  = 4'h0;
      cal_never = ($urandom_range(0, 4) == 0);
      cal_d     = int'($urandom_range(0, 300));
      bsy_never = ($urandom_range(0, 4) == 0);
      long_b    = ($urandom_range(0, 3) == 0);
      er_d1     = bsy_never ? -1 : int'($urandom_range(0, 10));
      er_d2     = long_b ? 200 : int'($urandom_range(5, 60));
      if (cal_never)      begin exp_state = 0; exp_err = 2'b01; end
      else if (bsy_never) begin exp_state = 0; exp_err = 2'b10; end
      else if (long_b)    begin exp_state = 0; exp_err = 2'b10; end
      else begin exp_state = 6; exp_err = 2'b00; model_count++; end
      tick(3);
      wr(0, 1, r);
      check($sformatf("rand%0d start", it), r, 2'b00);
      if (!cal_never) begin
        fork
          begin
            automatic int dl = cal_d;
            repeat (dl) @(posedge clk);
            calib_in = 4'hF;
          end
        join_none
      end
      tick(cal_never ? 1150 : 650);
      rd_chk(0, exp_state, $sformatf("rand%0d state", it));
      rd_chk(5, {30'd0, exp_err}, $sformatf("rand%0d err", it));
      rd_chk(4, model_count, $sformatf("rand%0d count", it));
      check($sformatf("rand%0d gate", it), packet_gate, (exp_state == 6) ? 1'b1 : 1'b0);
      wr(0, 0, r);
      wr(5, 3, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
